// File: rtl/gpmc_wb_bridge_sync_if.sv
// Wishbone classic bus between the GPMC bridge (master) and the fabric slave.
interface gpmc_wb_bridge_sync_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] wbm_address;
  logic [DATA_WIDTH-1:0] wbm_writedata;
  logic [DATA_WIDTH-1:0] wbm_readdata;
  logic                  wbm_write;
  logic                  wbm_strobe;
  logic                  wbm_cycle;
  logic                  wbm_ack;

  modport master (
    output wbm_address, wbm_writedata, wbm_write, wbm_strobe, wbm_cycle,
    input  wbm_readdata, wbm_ack
  );

  modport slave (
    input  wbm_address, wbm_writedata, wbm_write, wbm_strobe, wbm_cycle,
    output wbm_readdata, wbm_ack
  );
endinterface

// File: rtl/gpmc_wb_bridge_sync.sv
// Oversampling GPMC (muxed AD) to Wishbone classic master bridge, single clock domain.
// One Wishbone cycle per GPMC access, with host WAIT, bus timeout and error pulse.
module gpmc_wb_bridge_sync #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] gpmc_ad_in,
  output logic [DATA_WIDTH-1:0] gpmc_ad_out,
  output logic                  gpmc_ad_oe,
  input  logic                  gpmc_csn,
  input  logic                  gpmc_advn,
  input  logic                  gpmc_wein,
  input  logic                  gpmc_oen,
  output logic                  gpmc_wait,
  gpmc_wb_bridge_sync_if.master wb,
  output logic                  timeout_err
);
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, ADDR, CMD, WB_WR, WB_RD, DRIVE, DONE} state_t;

  logic [SYNC_STAGES-1:0] csn_sync, advn_sync, wein_sync, oen_sync;
  logic [DATA_WIDTH-1:0]  ad_sync [SYNC_STAGES];
  logic                   wein_prev, oen_prev;
  logic                   csn_s, advn_s, wein_s, oen_s, wein_rise, oen_fall, expired;
  logic [DATA_WIDTH-1:0]  ad_s;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d, rdata_q, rdata_d;
  logic                   cyc_q, cyc_d, we_q, we_d, wait_q, wait_d;
  logic                   oe_q, oe_d, terr_q, terr_d, abort_q, abort_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  // Input synchronisers; AD bus shares the control pipeline depth so samples stay aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      csn_sync  <= '1;
      advn_sync <= '1;
      wein_sync <= '1;
      oen_sync  <= '1;
      ad_sync   <= '{default: '0};
      wein_prev <= 1'b1;
      oen_prev  <= 1'b1;
    end else begin
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], gpmc_csn};
      advn_sync <= {advn_sync[SYNC_STAGES-2:0], gpmc_advn};
      wein_sync <= {wein_sync[SYNC_STAGES-2:0], gpmc_wein};
      oen_sync  <= {oen_sync[SYNC_STAGES-2:0], gpmc_oen};
      ad_sync[0] <= gpmc_ad_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) ad_sync[i] <= ad_sync[i-1];
      wein_prev <= wein_sync[SYNC_STAGES-1];
      oen_prev  <= oen_sync[SYNC_STAGES-1];
    end
  end

  assign csn_s     = csn_sync[SYNC_STAGES-1];
  assign advn_s    = advn_sync[SYNC_STAGES-1];
  assign wein_s    = wein_sync[SYNC_STAGES-1];
  assign oen_s     = oen_sync[SYNC_STAGES-1];
  assign ad_s      = ad_sync[SYNC_STAGES-1];
  assign wein_rise = wein_s & ~wein_prev;
  assign oen_fall  = ~oen_s & oen_prev;
  assign expired   = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      wait_q  <= 1'b0;
      oe_q    <= 1'b0;
      terr_q  <= 1'b0;
      abort_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      wait_q  <= wait_d;
      oe_q    <= oe_d;
      terr_q  <= terr_d;
      abort_q <= abort_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and next-output logic; every output comes from a flop.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    wait_d  = wait_q;
    oe_d    = 1'b0;
    terr_d  = 1'b0;
    abort_d = abort_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (!csn_s && !advn_s) begin
          addr_d  = ad_s[ADDR_WIDTH-1:0];
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (csn_s)        state_d = IDLE;
        else if (!advn_s) addr_d  = ad_s[ADDR_WIDTH-1:0];
        else              state_d = CMD;
      end
      CMD: begin
        if (csn_s) begin
          state_d = IDLE;
        end else if (wein_rise) begin
          wdata_d = ad_s;
          cyc_d   = 1'b1;
          we_d    = 1'b1;
          wait_d  = 1'b1;
          cnt_d   = '0;
          abort_d = 1'b0;
          state_d = WB_WR;
        end else if (oen_fall) begin
          cyc_d   = 1'b1;
          we_d    = 1'b0;
          wait_d  = 1'b1;
          cnt_d   = '0;
          abort_d = 1'b0;
          state_d = WB_RD;
        end
      end
      WB_WR, WB_RD: begin
        // A host that gives up mid-cycle still lets the slave finish; its read data is dropped.
        if (csn_s) abort_d = 1'b1;
        if (wb.wbm_ack || expired) begin
          cyc_d  = 1'b0;
          we_d   = 1'b0;
          wait_d = 1'b0;
          terr_d = ~wb.wbm_ack;
          if (state_q == WB_RD && !abort_q && !csn_s) begin
            rdata_d = wb.wbm_ack ? wb.wbm_readdata : '1;
            oe_d    = 1'b1;
            state_d = DRIVE;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRIVE: begin
        if (oen_s || csn_s) state_d = DONE;
        else                oe_d    = 1'b1;
      end
      DONE: begin
        if (csn_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign gpmc_ad_out      = rdata_q;
  assign gpmc_ad_oe       = oe_q;
  assign gpmc_wait        = wait_q;
  assign timeout_err      = terr_q;
  assign wb.wbm_address   = addr_q;
  assign wb.wbm_writedata = wdata_q;
  assign wb.wbm_write     = we_q;
  assign wb.wbm_strobe    = cyc_q;
  assign wb.wbm_cycle     = cyc_q;
endmodule

// File: tb/tb_gpmc_wb_bridge_sync.sv
// Self-checking bench for gpmc_wb_bridge_sync: host GPMC model, Wishbone slave model, scoreboard.
module tb_gpmc_wb_bridge_sync;
  logic        clk, reset;
  logic [15:0] ad_in, ad_out;
  logic        ad_oe, csn, advn, wein, oen, gpmc_wait, timeout_err;

  gpmc_wb_bridge_sync_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) wbif ();

  gpmc_wb_bridge_sync #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .SYNC_STAGES(2), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .gpmc_ad_in(ad_in), .gpmc_ad_out(ad_out), .gpmc_ad_oe(ad_oe),
    .gpmc_csn(csn), .gpmc_advn(advn), .gpmc_wein(wein), .gpmc_oen(oen), .gpmc_wait(gpmc_wait),
    .wb(wbif), .timeout_err(timeout_err)
  );

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          len;
    logic        stable;
    logic        wait_hi;
  } txn_t;

  txn_t exp_q[$];
  txn_t obs_q[$];
  int   pass_cnt = 0, chk_cnt = 0;
  int   terr_cnt = 0, oe_cnt = 0;

  // Slave model: acks slv_delay cycles after strobe rises, plus an injectable spurious ack.
  logic        slv_en = 1'b1, spur_ack = 1'b0;
  int          slv_delay = 0, slv_age = 0;
  logic [15:0] slv_rdata = 16'h0000;
  assign wbif.wbm_readdata = slv_rdata;
  assign wbif.wbm_ack = spur_ack | (slv_en && wbif.wbm_strobe && (slv_age == slv_delay));
  always @(posedge clk) slv_age <= wbif.wbm_strobe ? slv_age + 1 : 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus monitor: records each Wishbone cycle when strobe drops.
  logic mon_active = 1'b0;
  txn_t cur;
  always @(negedge clk) begin
    if (wbif.wbm_strobe) begin
      if (!mon_active) begin
        mon_active  = 1'b1;
        cur.we      = wbif.wbm_write;
        cur.addr    = wbif.wbm_address;
        cur.wdata   = wbif.wbm_writedata;
        cur.len     = 1;
        cur.stable  = wbif.wbm_cycle;
        cur.wait_hi = gpmc_wait;
      end else begin
        cur.len++;
        if (wbif.wbm_write !== cur.we || wbif.wbm_address !== cur.addr ||
            wbif.wbm_writedata !== cur.wdata || wbif.wbm_cycle !== 1'b1) cur.stable = 1'b0;
        if (gpmc_wait !== 1'b1) cur.wait_hi = 1'b0;
      end
    end else if (mon_active) begin
      mon_active = 1'b0;
      obs_q.push_back(cur);
    end
    if (timeout_err) terr_cnt++;
    if (ad_oe) oe_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_addr(input logic [15:0] a);
    ad_in = a; csn = 1'b0; advn = 1'b0;
    repeat (4) step();
    advn = 1'b1;
    repeat (4) step();
  endtask

  task automatic host_write_launch(input logic [15:0] d, output int lat);
    ad_in = d; wein = 1'b0;
    repeat (3) step();
    wein = 1'b1;
    lat = 0;
    while (wbif.wbm_strobe !== 1'b1 && lat < 20) begin step(); lat++; end
  endtask

  task automatic host_read_launch(output int lat);
    oen = 1'b0;
    lat = 0;
    while (wbif.wbm_strobe !== 1'b1 && lat < 20) begin step(); lat++; end
  endtask

  task automatic wait_not_busy();
    int n = 0;
    while (gpmc_wait !== 1'b0 && n < 100) begin step(); n++; end
  endtask

  task automatic host_release();
    csn = 1'b1; advn = 1'b1; wein = 1'b1; oen = 1'b1;
    repeat (4) step();
  endtask

  task automatic pop_pair(output txn_t e, output txn_t o, output bit ok);
    int n = 0;
    while (obs_q.size() == 0 && n < 50) begin step(); n++; end
    ok = (obs_q.size() != 0) && (exp_q.size() != 0);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    if (obs_q.size() != 0) o = obs_q.pop_front();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    chk_cnt++; if (wbif.wbm_cycle !== 1'b0 || wbif.wbm_strobe !== 1'b0 || wbif.wbm_write !== 1'b0)
      $display("FAIL reset_wb_ctrl got cyc=%b stb=%b we=%b exp 0", wbif.wbm_cycle, wbif.wbm_strobe, wbif.wbm_write); else pass_cnt++;
    chk_cnt++; if (wbif.wbm_address !== 16'h0 || wbif.wbm_writedata !== 16'h0)
      $display("FAIL reset_wb_data got a=%h d=%h exp 0", wbif.wbm_address, wbif.wbm_writedata); else pass_cnt++;
    chk_cnt++; if (ad_out !== 16'h0 || ad_oe !== 1'b0 || gpmc_wait !== 1'b0 || timeout_err !== 1'b0)
      $display("FAIL reset_gpmc got out=%h oe=%b wait=%b terr=%b exp 0", ad_out, ad_oe, gpmc_wait, timeout_err); else pass_cnt++;
    reset = 1'b0;
    step();
  endtask

  task automatic test_write();
    txn_t e, o; bit ok; int lat; int terr0 = terr_cnt;
    slv_en = 1'b1; slv_delay = 2;
    exp_q.push_back('{we: 1'b1, addr: 16'h0012, wdata: 16'hA5A5, len: 3, stable: 1'b1, wait_hi: 1'b1});
    host_addr(16'h0012);
    host_write_launch(16'hA5A5, lat);
    chk_cnt++; if (lat !== 3) $display("FAIL wr_launch_latency got %0d exp 3", lat); else pass_cnt++;
    wait_not_busy();
    chk_cnt++; if (gpmc_wait !== 1'b0) $display("FAIL wr_wait_release got %b exp 0", gpmc_wait); else pass_cnt++;
    host_release();
    pop_pair(e, o, ok);
    chk_cnt++; if (ok !== 1'b1) $display("FAIL wr_cycle_seen got %b exp 1", ok); else pass_cnt++;
    chk_cnt++; if (o.addr !== e.addr || o.wdata !== e.wdata || o.we !== e.we)
      $display("FAIL wr_payload got a=%h d=%h we=%b exp a=%h d=%h we=%b", o.addr, o.wdata, o.we, e.addr, e.wdata, e.we); else pass_cnt++;
    chk_cnt++; if (o.len !== e.len) $display("FAIL wr_stb_len got %0d exp %0d", o.len, e.len); else pass_cnt++;
    chk_cnt++; if (o.stable !== e.stable || o.wait_hi !== e.wait_hi)
      $display("FAIL wr_stable got stable=%b wait=%b exp 1 1", o.stable, o.wait_hi); else pass_cnt++;
    chk_cnt++; if (terr_cnt !== terr0) $display("FAIL wr_no_timeout got %0d pulses exp 0", terr_cnt - terr0); else pass_cnt++;
  endtask

  task automatic do_read(input logic [15:0] a, input string nm, input logic [15:0] exp_data,
                         input int exp_terr);
    txn_t e, o; bit ok; int lat, n; int terr0 = terr_cnt;
    host_addr(a);
    host_read_launch(lat);
    chk_cnt++; if (lat !== 3) $display("FAIL %s_launch_latency got %0d exp 3", nm, lat); else pass_cnt++;
    wait_not_busy();
    chk_cnt++; if (ad_out !== exp_data || ad_oe !== 1'b1)
      $display("FAIL %s_data got out=%h oe=%b exp out=%h oe=1", nm, ad_out, ad_oe, exp_data); else pass_cnt++;
    repeat (4) step();
    chk_cnt++; if (ad_oe !== 1'b1) $display("FAIL %s_oe_hold got %b exp 1", nm, ad_oe); else pass_cnt++;
    oen = 1'b1;
    n = 0;
    while (ad_oe !== 1'b0 && n < 20) begin step(); n++; end
    chk_cnt++; if (n !== 3) $display("FAIL %s_oe_release got %0d edges exp 3", nm, n); else pass_cnt++;
    host_release();
    pop_pair(e, o, ok);
    chk_cnt++; if (ok !== 1'b1 || o.addr !== e.addr || o.we !== e.we || o.len !== e.len || o.stable !== 1'b1)
      $display("FAIL %s_cycle got ok=%b a=%h we=%b len=%0d st=%b exp a=%h we=%b len=%0d st=1",
               nm, ok, o.addr, o.we, o.len, o.stable, e.addr, e.we, e.len); else pass_cnt++;
    chk_cnt++; if (terr_cnt - terr0 !== exp_terr)
      $display("FAIL %s_timeout_pulses got %0d exp %0d", nm, terr_cnt - terr0, exp_terr); else pass_cnt++;
  endtask

  task automatic test_read();
    slv_en = 1'b1; slv_delay = 5; slv_rdata = 16'h1234;
    exp_q.push_back('{we: 1'b0, addr: 16'h0034, wdata: 16'h0000, len: 6, stable: 1'b1, wait_hi: 1'b1});
    do_read(16'h0034, "rd", 16'h1234, 0);
  endtask

  task automatic test_timeout();
    slv_en = 1'b0; slv_rdata = 16'h5555;
    exp_q.push_back('{we: 1'b0, addr: 16'h0056, wdata: 16'h0000, len: 8, stable: 1'b1, wait_hi: 1'b1});
    do_read(16'h0056, "tmo", 16'hFFFF, 1);
    slv_en = 1'b1;
  endtask

  task automatic test_abort_addr();
    ad_in = 16'h0077; csn = 1'b0; advn = 1'b0;
    repeat (4) step();
    csn = 1'b1; advn = 1'b1;
    repeat (8) step();
    chk_cnt++; if (obs_q.size() !== 0 || gpmc_wait !== 1'b0)
      $display("FAIL abort_addr got cycles=%0d wait=%b exp 0 0", obs_q.size(), gpmc_wait); else pass_cnt++;
  endtask

  task automatic test_abort_read();
    txn_t e, o; bit ok; int lat; int oe0 = oe_cnt;
    slv_en = 1'b1; slv_delay = 4; slv_rdata = 16'hBEEF;
    exp_q.push_back('{we: 1'b0, addr: 16'h0078, wdata: 16'h0000, len: 5, stable: 1'b1, wait_hi: 1'b1});
    host_addr(16'h0078);
    host_read_launch(lat);
    csn = 1'b1; oen = 1'b1;
    wait_not_busy();
    repeat (6) step();
    pop_pair(e, o, ok);
    chk_cnt++; if (ok !== 1'b1 || o.addr !== e.addr || o.len !== e.len)
      $display("FAIL abort_rd_cycle got ok=%b a=%h len=%0d exp a=%h len=%0d", ok, o.addr, o.len, e.addr, e.len); else pass_cnt++;
    chk_cnt++; if (oe_cnt !== oe0) $display("FAIL abort_rd_oe got %0d drive cycles exp 0", oe_cnt - oe0); else pass_cnt++;
    chk_cnt++; if (ad_out !== 16'hFFFF) $display("FAIL abort_rd_discard got %h exp ffff", ad_out); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    txn_t e, o; bit ok; int lat;
    slv_en = 1'b1; slv_delay = 6;
    exp_q.push_back('{we: 1'b1, addr: 16'h0099, wdata: 16'h1111, len: 2, stable: 1'b1, wait_hi: 1'b1});
    host_addr(16'h0099);
    host_write_launch(16'h1111, lat);
    step();
    reset = 1'b1; csn = 1'b1; advn = 1'b1; wein = 1'b1; oen = 1'b1;
    step();
    chk_cnt++; if (wbif.wbm_cycle !== 1'b0 || wbif.wbm_strobe !== 1'b0 || wbif.wbm_write !== 1'b0 || gpmc_wait !== 1'b0)
      $display("FAIL midreset_outputs got cyc=%b stb=%b we=%b wait=%b exp 0", wbif.wbm_cycle, wbif.wbm_strobe,
               wbif.wbm_write, gpmc_wait); else pass_cnt++;
    reset = 1'b0;
    pop_pair(e, o, ok);
    chk_cnt++; if (ok !== 1'b1 || o.addr !== e.addr || o.len !== e.len)
      $display("FAIL midreset_cut got ok=%b a=%h len=%0d exp a=%h len=%0d", ok, o.addr, o.len, e.addr, e.len); else pass_cnt++;
    slv_delay = 0;
    exp_q.push_back('{we: 1'b1, addr: 16'h00AB, wdata: 16'h5A5A, len: 1, stable: 1'b1, wait_hi: 1'b1});
    host_addr(16'h00AB);
    host_write_launch(16'h5A5A, lat);
    wait_not_busy();
    host_release();
    pop_pair(e, o, ok);
    chk_cnt++; if (ok !== 1'b1 || o.addr !== e.addr || o.wdata !== e.wdata || o.we !== e.we || o.len !== e.len)
      $display("FAIL postreset_write got ok=%b a=%h d=%h we=%b len=%0d exp a=%h d=%h we=1 len=%0d",
               ok, o.addr, o.wdata, o.we, o.len, e.addr, e.wdata, e.len); else pass_cnt++;
  endtask

  task automatic test_spurious_ack();
    txn_t e, o; bit ok; int lat; int terr0 = terr_cnt;
    spur_ack = 1'b1;
    repeat (3) step();
    spur_ack = 1'b0;
    step();
    chk_cnt++; if (wbif.wbm_strobe !== 1'b0 || gpmc_wait !== 1'b0 || ad_out !== 16'h0000 || ad_oe !== 1'b0 ||
                   wbif.wbm_address !== 16'h00AB || obs_q.size() !== 0 || terr_cnt !== terr0)
      $display("FAIL spur_idle got stb=%b wait=%b out=%h oe=%b a=%h cyc=%0d exp 0 0 0000 0 00ab 0",
               wbif.wbm_strobe, gpmc_wait, ad_out, ad_oe, wbif.wbm_address, obs_q.size()); else pass_cnt++;
    slv_delay = 1;
    exp_q.push_back('{we: 1'b1, addr: 16'h00CD, wdata: 16'h0F0F, len: 2, stable: 1'b1, wait_hi: 1'b1});
    host_addr(16'h00CD);
    host_write_launch(16'h0F0F, lat);
    wait_not_busy();
    spur_ack = 1'b1;
    repeat (3) step();
    spur_ack = 1'b0;
    step();
    chk_cnt++; if (wbif.wbm_cycle !== 1'b0 || wbif.wbm_strobe !== 1'b0 || gpmc_wait !== 1'b0 || ad_oe !== 1'b0 ||
                   obs_q.size() !== 1 || terr_cnt !== terr0)
      $display("FAIL spur_done got cyc=%b stb=%b wait=%b oe=%b cycles=%0d exp 0 0 0 0 1",
               wbif.wbm_cycle, wbif.wbm_strobe, gpmc_wait, ad_oe, obs_q.size()); else pass_cnt++;
    host_release();
    pop_pair(e, o, ok);
    chk_cnt++; if (ok !== 1'b1 || o.addr !== e.addr || o.wdata !== e.wdata || o.len !== e.len)
      $display("FAIL spur_write got ok=%b a=%h d=%h len=%0d exp a=%h d=%h len=%0d",
               ok, o.addr, o.wdata, o.len, e.addr, e.wdata, e.len); else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1; ad_in = 16'h0; csn = 1'b1; advn = 1'b1; wein = 1'b1; oen = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_abort_addr();
    test_abort_read();
    test_reset_mid();
    test_spurious_ack();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/gpmc_wb_bridge_sync.md
# gpmc_wb_bridge_sync

Single-clock GPMC-to-Wishbone master bridge for the BeagleWire FPGA fabric: it oversamples the asynchronous, address/data-multiplexed GPMC bus from the BeagleBone host in the `clk` domain, launches exactly one Wishbone classic cycle per GPMC access, and holds that cycle until the slave acknowledges. It generalises the first-generation bridge with parametrised widths and synchroniser depth, a proper stb/ack handshake, a host WAIT output, a bus timeout and an error flag. The pad tristate (SB_IO) is instantiated outside the bridge.

## Interface
- `ADDR_WIDTH`, 16: Wishbone address width; the low ADDR_WIDTH bits of the AD bus are latched.
- `DATA_WIDTH`, 16: GPMC AD bus and Wishbone data width.
- `SYNC_STAGES`, 2: synchroniser flops on every GPMC input; minimum 2.
- `TIMEOUT_CYCLES`, 255: number of `clk` cycles a Wishbone cycle may wait for ack; 0 disables the timeout.
- `clk` in 1: system clock; the only clock in the block.
- `reset` in 1: synchronous, active-high reset.
- `gpmc_ad_in` in DATA_WIDTH: AD bus value from the pad.
- `gpmc_ad_out` out DATA_WIDTH: read data driven to the pad.
- `gpmc_ad_oe` out 1: pad output enable, high = drive.
- `gpmc_csn` in 1: chip select, active low.
- `gpmc_advn` in 1: address valid, active low.
- `gpmc_wein` in 1: write enable, active low.
- `gpmc_oen` in 1: output enable, active low.
- `gpmc_wait` out 1: high = bridge busy; the host must extend the access.
- `wbm_address` out ADDR_WIDTH: Wishbone address.
- `wbm_writedata` out DATA_WIDTH: Wishbone write data.
- `wbm_readdata` in DATA_WIDTH: Wishbone read data.
- `wbm_write` out 1: high = write cycle.
- `wbm_strobe` out 1: Wishbone STB.
- `wbm_cycle` out 1: Wishbone CYC.
- `wbm_ack` in 1: slave acknowledge.
- `timeout_err` out 1: one-cycle pulse when a cycle is ended by timeout.

## Operation
- Synchronisation: csn, advn, wein and oen each pass through SYNC_STAGES flops. `gpmc_ad_in` passes through the same number of flops, so data stays aligned with its controls. Edge detection uses one further registered copy.
- FSM states: IDLE, ADDR, CMD, WB_WR, WB_RD, DRIVE, DONE.
- IDLE: when synced csn=0 and advn=0, latch the AD bus into the address register every cycle and go to ADDR.
- ADDR: keep latching while advn=0. When advn rises, freeze the address and go to CMD.
- CMD, write: a rising edge of synced wein captures the AD bus into `wbm_writedata`, asserts cyc/stb/we and goes to WB_WR.
- CMD, read: a falling edge of synced oen asserts cyc/stb with we=0 and goes to WB_RD.
- Both `gpmc_wait` and strobe go high on the same edge that leaves CMD.
- WB_WR and WB_RD: cyc, stb, we, address and writedata stay stable until `wbm_ack`=1 or the timeout expires.
  - On ack in WB_WR: deassert cyc/stb/we and wait, go to DONE.
  - On ack in WB_RD: register `wbm_readdata` into `gpmc_ad_out`, deassert cyc/stb and wait, go to DRIVE.
- DRIVE: `gpmc_ad_oe`=1 while synced oen=0 and csn=0. When either one rises, `gpmc_ad_oe`=0 and the FSM goes to DONE.
- DONE: wait for synced csn=1, then go to IDLE.
- Timeout: a counter loads 0 on cycle launch and increments each cycle in WB_WR/WB_RD. When it reaches TIMEOUT_CYCLES without ack, the bridge ends the cycle exactly as if acked and pulses `timeout_err`. A read that times out returns all ones.
- `wbm_ack` outside WB_WR/WB_RD is ignored.
- csn rising in ADDR or CMD: return to IDLE with no Wishbone cycle.
- csn rising in WB_WR or WB_RD: the Wishbone cycle still runs to ack or timeout; read data is discarded; the FSM goes to DONE.
- Both wein and oen low in CMD: write takes priority.
- `gpmc_ad_oe` is never high outside DRIVE.

## Timing
- Reset values: all wbm outputs 0, `gpmc_ad_out`=0, `gpmc_ad_oe`=0, `gpmc_wait`=0, `timeout_err`=0, FSM in IDLE, counter 0.
- Reset asserted mid-cycle: everything returns to reset values on the next edge, including dropping cyc/stb with no ack required.
- Launch latency: `wbm_strobe` rises SYNC_STAGES+1 `clk` edges after the wein rising edge (write) or oen falling edge (read) at the pin. With the default that is 3 edges.
- Ack latency: with ack sampled high at edge k, cyc/stb/`gpmc_wait` are low and `gpmc_ad_out` is valid after edge k+1. `gpmc_ad_oe` is high after edge k+1.
- Minimum Wishbone cycle is 1 cycle (ack in the same cycle stb first rises). No back-to-back cycle starts until the FSM passes through IDLE.
- The host must hold oen low at least SYNC_STAGES+1 cycles after `gpmc_wait` falls.

## Test plan
- Write: addr 0x0012, data 0xA5A5, slave acks after 2 cycles -> one cycle with `wbm_address`=0x0012, `wbm_writedata`=0xA5A5, `wbm_write`=1, stb held 3 cycles, `gpmc_wait` then low, no `timeout_err`.
- Read: addr 0x0034, slave returns 0x1234 with ack after 5 cycles -> `gpmc_ad_out`=0x1234, `gpmc_ad_oe` high from the edge after ack until 3 cycles after oen rises.
- Timeout: TIMEOUT_CYCLES=8, read with no ack -> stb low after 8 cycles, `timeout_err` pulses once, `gpmc_ad_out`=0xFFFF.
- Abort: csn deasserted during ADDR -> no wbm_cycle. csn deasserted during WB_RD with ack 4 cycles later -> cycle completes, `gpmc_ad_oe` never asserts.
- Reset: `reset` raised while stb=1 -> cyc/stb/we/`gpmc_wait`=0 after the next edge, and the FSM accepts a new write immediately after.
- Spurious `wbm_ack` pulses in IDLE and DONE -> no output change.
